// File: rtl/p_uart_recv.sv
// p_uart_recv: 8N1 UART receiver that assembles 16-byte packets,
// with stop-bit checking and an inter-byte idle timeout.
module p_uart_recv #(
  parameter int CLK_FREQ     = 50000000,
  parameter int UART_BPS     = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         uart_rxd,
  output logic         uart_rx_busy,
  output logic [7:0]   rx_byte,
  output logic         rx_byte_done,
  output logic [3:0]   rx_cnt,
  output logic [127:0] uart_dout,
  output logic         uart_done,
  output logic         frame_err
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int TO_CNT  = TIMEOUT_BITS * BPS_CNT;
  localparam int CW      = $clog2(BPS_CNT + 1);
  localparam int TW      = $clog2(TO_CNT + 1);

  localparam logic [CW-1:0] HALF    = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] FULL    = CW'(BPS_CNT - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CNT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic           rxd_d0;
  logic           rxd_d1;
  logic           rxd_d2;
  logic           line;
  logic           fall;
  logic [1:0]     state;
  logic [CW-1:0]  clk_cnt;
  logic [TW-1:0]  idle_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic [127:0]   pkt_buf;

  // rxd_d2 only delays the synchronised line for edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_d0 <= 1'b1;
      rxd_d1 <= 1'b1;
      rxd_d2 <= 1'b1;
    end else begin
      rxd_d0 <= uart_rxd;
      rxd_d1 <= rxd_d0;
      rxd_d2 <= rxd_d1;
    end
  end

  assign line = rxd_d1;
  assign fall = rxd_d2 & ~rxd_d1;

  assign uart_rx_busy = (state != IDLE) || (rx_cnt != 4'd0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      idle_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      pkt_buf      <= '0;
      rx_byte      <= '0;
      rx_byte_done <= 1'b0;
      rx_cnt       <= '0;
      uart_dout    <= '0;
      uart_done    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_byte_done <= 1'b0;
      uart_done    <= 1'b0;
      frame_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (fall) begin
            state    <= START;
            idle_cnt <= '0;
          end else if (rx_cnt != 4'd0) begin
            // a stalled partial packet is dropped
            if (idle_cnt == TO_LAST) begin
              frame_err <= 1'b1;
              rx_cnt    <= '0;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF) begin
            clk_cnt <= '0;
            state   <= line ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            shift   <= {line, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            state   <= IDLE;
            if (line) begin
              rx_byte      <= shift;
              rx_byte_done <= 1'b1;
              rx_cnt       <= rx_cnt + 1'b1;
              pkt_buf[{rx_cnt, 3'b000} +: 8] <= shift;
              if (rx_cnt == 4'd15) begin
                uart_dout <= {shift, pkt_buf[119:0]};
                uart_done <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              rx_cnt    <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p_uart_recv.sv
// tb_p_uart_recv: table vectors, corner sequences and random frames
// checked against a byte/packet-level model of the receiver.
module tb_p_uart_recv;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         uart_rxd;
  logic         uart_rx_busy;
  logic [7:0]   rx_byte;
  logic         rx_byte_done;
  logic [3:0]   rx_cnt;
  logic [127:0] uart_dout;
  logic         uart_done;
  logic         frame_err;

  p_uart_recv #(
    .CLK_FREQ(1000000),
    .UART_BPS(100000),
    .TIMEOUT_BITS(20)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .uart_rxd(uart_rxd),
    .uart_rx_busy(uart_rx_busy),
    .rx_byte(rx_byte),
    .rx_byte_done(rx_byte_done),
    .rx_cnt(rx_cnt),
    .uart_dout(uart_dout),
    .uart_done(uart_done),
    .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // byte/packet-level expectations
  logic [7:0]   exp_bytes[$];
  logic [127:0] exp_pkts[$];
  int           exp_ferr = 0;
  logic [127:0] part = '0;
  int           part_n = 0;
  int           n_rbd = 0;
  int           n_done = 0;
  int           n_ferr = 0;

  task automatic model_byte(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_bytes.push_back(b);
      part[8*part_n +: 8] = b;
      part_n++;
      if (part_n == 16) begin
        exp_pkts.push_back(part);
        part_n = 0;
      end
    end else begin
      exp_ferr++;
      part_n = 0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    wait_cyc(10);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    model_byte(b, stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
  endtask

  // event monitor
  logic [127:0] last_dout = '0;
  logic         p_rbd = 1'b0;
  logic         p_done = 1'b0;
  logic         p_ferr = 1'b0;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      last_dout = uart_dout;
      p_rbd  = 1'b0;
      p_done = 1'b0;
      p_ferr = 1'b0;
    end else begin
      if (rx_byte_done) begin
        n_rbd++;
        chk("byte_expected", 128'(exp_bytes.size() != 0), 128'(1));
        if (exp_bytes.size() != 0)
          chk("rx_byte", 128'(rx_byte), 128'(exp_bytes.pop_front()));
      end
      if (uart_done) begin
        n_done++;
        chk("done_with_byte", 128'(rx_byte_done), 128'(1));
        chk("pkt_expected", 128'(exp_pkts.size() != 0), 128'(1));
        if (exp_pkts.size() != 0)
          chk("uart_dout", uart_dout, exp_pkts.pop_front());
      end else begin
        chk("dout_hold", uart_dout, last_dout);
      end
      if (frame_err) begin
        n_ferr++;
        chk("ferr_expected", 128'(exp_ferr > 0), 128'(1));
        if (exp_ferr > 0) exp_ferr--;
        chk("ferr_vs_done", 128'(uart_done), 128'(0));
      end
      if (p_rbd)  chk("rbd_single", 128'(rx_byte_done), 128'(0));
      if (p_done) chk("done_single", 128'(uart_done), 128'(0));
      if (p_ferr) chk("ferr_single", 128'(frame_err), 128'(0));
      last_dout = uart_dout;
      p_rbd  = rx_byte_done;
      p_done = uart_done;
      p_ferr = frame_err;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [3:0] exp_cnt;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vec[8];

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"}, 128'(rx_cnt), 128'(0));
    chk({tag, "_busy"}, 128'(uart_rx_busy), 128'(0));
    chk({tag, "_dout"}, uart_dout, 128'(0));
    chk({tag, "_byte"}, 128'(rx_byte), 128'(0));
    chk({tag, "_pulses"},
        128'({rx_byte_done, uart_done, frame_err}), 128'(0));
  endtask

  initial begin
    int d0;
    int f0;
    int r0;
    logic [7:0]   b;
    logic [127:0] keep;

    vec[0] = '{8'h55, 1'b1, 4'd1, 8'h55};
    vec[1] = '{8'h00, 1'b1, 4'd2, 8'h00};
    vec[2] = '{8'hFF, 1'b1, 4'd3, 8'hFF};
    vec[3] = '{8'h80, 1'b1, 4'd4, 8'h80};
    vec[4] = '{8'h01, 1'b1, 4'd5, 8'h01};
    vec[5] = '{8'hA5, 1'b0, 4'd0, 8'h01};
    vec[6] = '{8'h3C, 1'b1, 4'd1, 8'h3C};
    vec[7] = '{8'hC3, 1'b0, 4'd0, 8'h3C};

    sys_rst  = 1'b1;
    uart_rxd = 1'b1;
    wait_cyc(3);
    chk_reset_vals("reset");
    sys_rst = 1'b0;
    wait_cyc(5);

    for (int i = 0; i < 8; i++) begin
      send_byte(vec[i].d, vec[i].stop);
      wait_cyc(3);
      chk("tbl_cnt", 128'(rx_cnt), 128'(vec[i].exp_cnt));
      chk("tbl_byte", 128'(rx_byte), 128'(vec[i].exp_byte));
      chk("tbl_busy", 128'(uart_rx_busy), 128'(vec[i].exp_cnt != 0));
      chk("tbl_dout", uart_dout, 128'(0));
    end

    r0 = n_rbd;
    f0 = n_ferr;
    uart_rxd = 1'b0;
    wait_cyc(3);
    uart_rxd = 1'b1;
    chk("glitch_busy_mid", 128'(uart_rx_busy), 128'(1));
    wait_cyc(20);
    chk("glitch_busy", 128'(uart_rx_busy), 128'(0));
    chk("glitch_cnt", 128'(rx_cnt), 128'(0));
    chk("glitch_pulses", 128'((n_rbd - r0) + (n_ferr - f0)), 128'(0));

    d0 = n_done;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    wait_cyc(2);
    chk("burst_done_cnt", 128'(n_done - d0), 128'(1));
    chk("burst_dout", uart_dout,
        128'h0F0E0D0C0B0A09080706050403020100);
    chk("burst_cnt", 128'(rx_cnt), 128'(0));

    keep = uart_dout;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1);
    f0 = n_ferr;
    exp_ferr++;
    part_n = 0;
    wait_cyc(150);
    chk("to_early_cnt", 128'(rx_cnt), 128'(7));
    chk("to_early_ferr", 128'(n_ferr - f0), 128'(0));
    wait_cyc(55);
    chk("to_ferr", 128'(n_ferr - f0), 128'(1));
    chk("to_cnt", 128'(rx_cnt), 128'(0));
    chk("to_dout", uart_dout, keep);
    d0 = n_done;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    wait_cyc(2);
    chk("to_next_done", 128'(n_done - d0), 128'(1));

    for (int i = 0; i < 60; i++) begin
      b = 8'($urandom);
      send_byte(b, $urandom_range(0, 9) != 0);
      wait_cyc($urandom_range(0, 40));
      chk("rand_cnt", 128'(rx_cnt), 128'(part_n));
    end
    if (part_n != 0) begin
      exp_ferr++;
      part_n = 0;
    end
    wait_cyc(210);
    chk("flush_cnt", 128'(rx_cnt), 128'(0));

    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_rxd = b[4];
    wait_cyc(5);
    chk("pre_rst_busy", 128'(uart_rx_busy), 128'(1));
    chk("pre_rst_cnt", 128'(rx_cnt), 128'(8));
    sys_rst = 1'b1;
    uart_rxd = 1'b1;
    exp_bytes.delete();
    exp_pkts.delete();
    exp_ferr = 0;
    part_n = 0;
    wait_cyc(1);
    chk_reset_vals("midrst");
    wait_cyc(3);
    sys_rst = 1'b0;
    r0 = n_rbd;
    f0 = n_ferr;
    d0 = n_done;
    wait_cyc(50);
    chk("post_rst_quiet",
        128'((n_rbd - r0) + (n_ferr - f0) + (n_done - d0)), 128'(0));
    for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b1);
    wait_cyc(2);
    chk("ff_done_cnt", 128'(n_done - d0), 128'(1));
    chk("ff_dout", uart_dout, {128{1'b1}});
    chk("ff_cnt", 128'(rx_cnt), 128'(0));

    wait_cyc(20);
    chk("left_bytes", 128'(exp_bytes.size()), 128'(0));
    chk("left_pkts", 128'(exp_pkts.size()), 128'(0));
    chk("left_ferr", 128'(exp_ferr), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
